// File: rtl/alu_div_sequencer.sv
// alu_div_sequencer
//   Multi-cycle unsigned restoring divider. It has no subtractor of its own.
//   Each RUN cycle it drives the shared datapath ALU with a subtract of the
//   shifted trial value minus the divisor. It then uses the ALU result and
//   the less flag to decide one quotient bit.
//
// Ports
//   clk_i        : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   start_i      : division request, only sampled in IDLE
//   dividend_i   : unsigned dividend, captured on accepted start
//   divisor_i    : unsigned divisor, captured on accepted start
//   busy_o       : high while RUN or DONE
//   done_o       : one-cycle completion pulse (DONE state)
//   quotient_o   : registered quotient, held until the next DONE
//   remainder_o  : registered remainder, held until the next DONE
//   div_zero_o   : registered divide-by-zero indication
//   alu_src1_o   : ALU operand 1 (trial value during RUN, else 0)
//   alu_src2_o   : ALU operand 2 (divisor during RUN, else 0)
//   alu_op_o     : ALU operation select (ALU_SUB during RUN, else 0)
//   alu_result_i : ALU result
//   alu_less_i   : ALU less flag (result sign)
module alu_div_sequencer #(
  parameter int unsigned WIDTH   = 16,
  parameter logic [3:0]  ALU_SUB = 4'd6
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic [31:0]      alu_src1_o,
  output logic [31:0]      alu_src2_o,
  output logic [3:0]       alu_op_o,
  input  logic [31:0]      alu_result_i,
  input  logic             alu_less_i
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] v_q, v_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dzo_q, dzo_d;

  // Shifted trial value: partial remainder with the next dividend bit appended.
  logic [WIDTH:0]   s;

  // Only the low WIDTH+1 result bits carry a remainder. The sign arrives via alu_less_i.
  logic             unused_result;
  assign unused_result = ^alu_result_i[31:WIDTH+1];

  assign s = {r_q[WIDTH-1:0], d_q[cnt_q]};

  always_comb begin
    alu_src1_o = '0;
    alu_src2_o = '0;
    alu_op_o   = '0;
    if (state_q == RUN) begin
      alu_src1_o = 32'(s);
      alu_src2_o = 32'(v_q);
      alu_op_o   = ALU_SUB;
    end
  end

  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    v_d     = v_q;
    r_d     = r_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dz_d    = dz_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dzo_d   = dzo_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          d_d   = dividend_i;
          v_d   = divisor_i;
          r_d   = '0;
          q_d   = '0;
          cnt_d = CW'(WIDTH - 1);
          if (divisor_i == '0) begin
            state_d = DONE;
            dz_d    = 1'b1;
            quot_d  = '1;
            rem_d   = dividend_i;
            dzo_d   = 1'b1;
          end else begin
            state_d = RUN;
            dz_d    = 1'b0;
          end
        end
      end
      RUN: begin
        if (alu_less_i) begin
          r_d        = s;
          q_d[cnt_q] = 1'b0;
        end else begin
          r_d        = alu_result_i[WIDTH:0];
          q_d[cnt_q] = 1'b1;
        end
        // The output registers take the post-step values so the final bit
        // is present in the DONE cycle.
        if (cnt_q == '0) begin
          state_d = DONE;
          quot_d  = q_d;
          rem_d   = r_d[WIDTH-1:0];
          dzo_d   = dz_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      d_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dzo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      v_q     <= v_d;
      r_q     <= r_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dz_q    <= dz_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dzo_q   <= dzo_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;
  assign div_zero_o  = dzo_q;

endmodule

// File: tb/tb_alu_div_sequencer.sv
// tb_alu_div_sequencer
//   Drives directed division vectors into alu_div_sequencer. A combinational
//   ALU model sits beside the DUT. A scoreboard queue holds the expected
//   quotient, remainder and flag, the cycle done_o must appear in, and the
//   number of subtract cycles. A negedge monitor checks each done_o
//   against the queue.
module tb_alu_div_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dvd = '0;
  logic [15:0] dvs = '0;
  logic        busy, done;
  logic [15:0] quot, rem;
  logic        dz;
  logic [31:0] src1, src2, alu_res;
  logic [3:0]  op;
  logic        less;

  alu_div_sequencer #(.WIDTH(16), .ALU_SUB(4'd6)) dut (
    .clk_i(clk), .rst_n(rst_n), .start_i(start),
    .dividend_i(dvd), .divisor_i(dvs),
    .busy_o(busy), .done_o(done),
    .quotient_o(quot), .remainder_o(rem), .div_zero_o(dz),
    .alu_src1_o(src1), .alu_src2_o(src2), .alu_op_o(op),
    .alu_result_i(alu_res), .alu_less_i(less)
  );

  always #5 clk = ~clk;

  // Datapath ALU model: op 6 subtracts, anything else adds.
  assign alu_res = (op == 4'd6) ? (src1 - src2) : (src1 + src2);
  assign less    = alu_res[31];

  typedef struct {
    logic [15:0] q;
    logic [15:0] r;
    logic        dz;
    int unsigned due;
    int unsigned nalu;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned opcnt = 0;
  int          total = 0;
  int          bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count subtract cycles and score each done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      opcnt = 0;
    end else begin
      if (op == 4'd6) opcnt++;
      if (done) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected no pending result", cyc);
        end else begin
          e = sb.pop_front();
          chk("quotient", 32'(quot), 32'(e.q));
          chk("remainder", 32'(rem), 32'(e.r));
          chk("div_zero", 32'(dz), 32'(e.dz));
          chk("done_cycle", cyc, e.due);
          chk("sub_cycles", opcnt, e.nalu);
          chk("busy_in_done", 32'(busy), 32'd1);
        end
        opcnt = 0;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit push,
                       input logic [15:0] eq, input logic [15:0] er, input logic edz,
                       input int unsigned nalu);
    @(negedge clk);
    dvd   = a;
    dvs   = b;
    start = 1'b1;
    if (push) sb.push_back('{eq, er, edz, (b == 16'd0) ? cyc + 1 : cyc + 17, nalu});
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_empty();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic div(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] eq, input logic [15:0] er, input logic edz,
                     input int unsigned nalu);
    issue(a, b, 1'b1, eq, er, edz, nalu);
    wait_empty();
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quot", 32'(quot), 32'd0);
    chk("rst_rem", 32'(rem), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    chk("rst_src1", src1, 32'd0);
    chk("rst_src2", src2, 32'd0);
    chk("rst_op", 32'(op), 32'd0);
  endtask

  initial begin
    bit seen;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs();
    rst_n = 1'b1;

    div(16'd100, 16'd7, 16'd14, 16'd2, 1'b0, 16);
    div(16'hFFFF, 16'd1, 16'hFFFF, 16'd0, 1'b0, 16);
    div(16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 1'b0, 16);
    div(16'd3, 16'd9, 16'd0, 16'd3, 1'b0, 16);
    div(16'd0, 16'd5, 16'd0, 16'd0, 1'b0, 16);
    div(16'd5, 16'd0, 16'hFFFF, 16'd5, 1'b1, 0);

    // Start pulses during RUN and DONE are ignored; outputs hold on start.
    issue(16'd100, 16'd7, 1'b1, 16'd14, 16'd2, 1'b0, 16);
    @(negedge clk);
    chk("hold_quot", 32'(quot), 32'h0000FFFF);
    chk("hold_rem", 32'(rem), 32'd5);
    chk("hold_dz", 32'(dz), 32'd1);
    chk("busy_run", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    dvd = 16'd50; dvs = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    dvd = 16'd50; dvs = 16'd3; start = 1'b1;
    @(negedge clk);
    sb.push_back('{16'd16, 16'd2, 1'b0, cyc + 17, 16});
    @(posedge clk);
    #1 start = 1'b0;
    wait_empty();

    // Reset in the middle of RUN.
    issue(16'd1000, 16'd13, 1'b0, 16'd0, 16'd0, 1'b0, 0);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    div(16'd1000, 16'd13, 16'd76, 16'd12, 1'b0, 16);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
